// File: rtl/deser1_8_if.sv
// Handshake and serial bus between the serial source/consumer and the deserialiser.
// The master side drives the strobe/data/control lines, the slave returns the assembled word and status.
interface deser1_8_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             sync;
  logic             dir;
  logic             d;
  logic             rdy;
  logic             clr;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             busy;
  logic             ovr;
  logic             frmErr;

  modport master (
    output en, sync, dir, d, rdy, clr,
    input  data, valid, busy, ovr, frmErr
  );

  modport slave (
    input  en, sync, dir, d, rdy, clr,
    output data, valid, busy, ovr, frmErr
  );
endinterface

// File: rtl/deser1_8.sv
// Serial-in, parallel-out receiver: assembles SYNC-framed bits into words (MSB- or LSB-first)
// and presents them on a registered VALID/RDY output with sticky overrun and framing-error flags.
module deser1_8 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  deser1_8_if.slave  bus
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dirLatch_q, dirLatch_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             frmErr_q, frmErr_d;

  logic             start;
  logic             complete;
  logic             useDir;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] dLow;
  logic [WIDTH-1:0] dHigh;
  logic [WIDTH-1:0] word;

  // A SYNC strobe starts from an empty register with the live DIR, so the first bit
  // lands in the right place even when it also aborts a frame or completes a 1-bit frame.
  always_comb begin
    start    = bus.en && bus.sync;
    complete = 1'b0;
    if (bus.en) begin
      if (bus.sync) begin
        complete = (WIDTH == 1);
      end else begin
        complete = (state_q == SHIFT) && (count_q == CNT_W'(WIDTH - 1));
      end
    end
    useDir          = start ? bus.dir : dirLatch_q;
    base            = start ? '0 : shift_q;
    dLow            = '0;
    dLow[0]         = bus.d;
    dHigh           = '0;
    dHigh[WIDTH-1]  = bus.d;
    word            = useDir ? ((base << 1) | dLow) : ((base >> 1) | dHigh);
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    count_d    = count_q;
    dirLatch_d = dirLatch_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    frmErr_d   = frmErr_q;

    if (bus.clr) begin
      ovr_d    = 1'b0;
      frmErr_d = 1'b0;
    end

    if (start) begin
      shift_d    = word;
      count_d    = CNT_W'(1);
      dirLatch_d = bus.dir;
      state_d    = SHIFT;
      if (state_q == SHIFT) begin
        frmErr_d = 1'b1;
      end
    end else if (bus.en && (state_q == SHIFT)) begin
      shift_d = word;
      count_d = count_q + CNT_W'(1);
    end

    // A consumer taking the old word on the completion edge frees DATA for the new one.
    if (complete) begin
      state_d = IDLE;
      count_d = '0;
      if (!valid_q || bus.rdy) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.rdy) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      count_q    <= '0;
      dirLatch_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
      frmErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      count_q    <= count_d;
      dirLatch_q <= dirLatch_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
      frmErr_q   <= frmErr_d;
    end
  end

  assign bus.data   = data_q;
  assign bus.valid  = valid_q;
  assign bus.busy   = (state_q == SHIFT);
  assign bus.ovr    = ovr_q;
  assign bus.frmErr = frmErr_q;

endmodule

// File: doc/deser1_8.md
Name: deser1_8

Overview:
Serial-in, parallel-out receiver. It sits directly downstream of the team's 8-bit parallel-in/1-out shift register and consumes its serial Q output. Bits are captured on bit-strobe cycles and assembled into bytes, MSB-first or LSB-first. Each completed byte is presented on a registered output with a VALID/RDY handshake, plus sticky overrun and framing-error flags.

Parameters:
WIDTH, 8, bits per frame and width of DATA.
CNT_W, 3, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
CLK      in   1      system clock, 100 MHz, all logic on rising edge
RST      in   1      reset, asynchronous, active-low (0 = reset)
EN       in   1      bit strobe; D is sampled only on cycles with EN=1
SYNC     in   1      frame start; qualified by EN; marks D as first bit of a new frame
DIR      in   1      bit order: 1 = MSB first (left shift), 0 = LSB first (right shift)
D        in   1      serial data in
RDY      in   1      consumer accepts DATA when VALID=1 and RDY=1 at a rising edge
CLR      in   1      synchronous clear of OVR and FRM_ERR
DATA     out  WIDTH  last completed byte, registered
VALID    out  1      DATA holds an unconsumed byte
BUSY     out  1      frame in progress (state SHIFT)
OVR      out  1      sticky: a completed byte was dropped
FRM_ERR  out  1      sticky: a frame was aborted by SYNC mid-frame

Behaviour:
- Reset (RST=0, asynchronous): shift reg=0, bit count=0, state IDLE, dir latch=0, DATA=0, VALID=0, BUSY=0, OVR=0, FRM_ERR=0. Reset takes effect immediately, including mid-frame. After release, the partial frame is lost.
- States: IDLE and SHIFT. BUSY=1 exactly in SHIFT.
- IDLE, EN=1, SYNC=1:
  - capture D as bit 1 and latch DIR into the dir latch
  - count <= 1, go to SHIFT
- IDLE, EN=1, SYNC=0: ignored.
- EN=0: no state or data change, except the handshake and CLR.
- SHIFT, EN=1, SYNC=0: capture D, count++.
  - dir latch=1: sh <= {sh[WIDTH-2:0], D}
  - dir latch=0: sh <= {D, sh[WIDTH-1:1]}
  - DIR changes mid-frame are ignored; only the dir latch is used.
- Completion, on the strobe with count = WIDTH-1 (the WIDTH-th bit):
  - the assembled word, including the current D, is written to DATA at that edge
  - VALID=1 from the next cycle; state returns to IDLE
  - latency: 0 cycles after the last-bit edge
- Back-to-back frames: SYNC may arrive on the very next EN strobe after completion.
- SHIFT, EN=1, SYNC=1 (abort):
  - FRM_ERR <= 1 and the partial frame is discarded
  - D is taken as bit 1 of the new frame; count <= 1; DIR is re-latched; state stays SHIFT
- Handshake:
  - VALID && RDY at an edge clears VALID.
  - DATA holds its value while VALID=1, and also after VALID clears.
- Completion with VALID=1 and RDY=1 in the same cycle: the old byte is consumed, DATA loads the new byte, VALID stays 1, no OVR.
- Completion with VALID=1 and RDY=0: the new byte is dropped, DATA is unchanged, OVR <= 1.
- CLR=1 clears OVR and FRM_ERR at the edge. If a set event occurs in the same cycle, set wins.
- RDY while VALID=0: no effect.
- WIDTH=1 (degenerate): each SYNC+EN strobe completes a frame immediately.

Test Plan:
1. MSB-first: DIR=1, RDY=0, D=1,0,1,0,0,1,0,1 on 8 strobes spaced 3 clocks, SYNC on the first -> BUSY=1 during the frame; after the 8th edge DATA=0xA5, VALID=1, BUSY=0.
2. LSB-first: DIR=0, D=0,0,1,1,1,1,0,0 -> DATA=0x3C. Toggle DIR after bit 3 -> still 0x3C.
3. Overrun: frames 0x11 then 0x22 with RDY=0 -> DATA=0x11, OVR=1. RDY pulse -> VALID=0. CLR pulse -> OVR=0.
4. Simultaneous: frame 0x11 pending, RDY=1 held on the last-bit edge of frame 0x22 -> DATA=0x22, VALID=1, OVR=0.
5. Abort and idle: SYNC on bit 5 of a frame, then a full frame 0xF0 -> FRM_ERR=1, DATA=0xF0. EN strobes without SYNC in IDLE -> no change.
6. Reset mid-frame: RST=0 after bit 3 -> all outputs 0 in the same cycle. After release, 8 strobes without SYNC -> VALID remains 0.
